// File: rtl/rv64_mem_pkg.sv
// Shared types and widths for the rv64 memory arbiter.
// Used by rv64_mem_arbiter and its priority sub-module rv64_arb_prio.
package rv64_mem_pkg;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
    typedef enum logic {ARB_IF, ARB_D} arb_id_e;
endpackage

// File: rtl/rv64_arb_prio.sv
// Grant selection between fetch and data, with the fetch anti-starvation counter.
// Data wins conflicts until fetch has lost STARVE_LIMIT in a row.
module rv64_arb_prio
    import rv64_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    arb_en,
    input  logic    if_valid,
    input  logic    d_valid,
    output logic    grant,
    output arb_id_e grant_id
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       conflict;

    assign conflict = arb_en && if_valid && d_valid;

    always_comb begin
        grant    = 1'b0;
        grant_id = ARB_D;
        if (arb_en) begin
            if (if_valid && d_valid) begin
                grant    = 1'b1;
                grant_id = (starve_cnt == LIMIT) ? ARB_IF : ARB_D;
            end else if (if_valid) begin
                grant    = 1'b1;
                grant_id = ARB_IF;
            end else if (d_valid) begin
                grant    = 1'b1;
                grant_id = ARB_D;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (grant && grant_id == ARB_IF) begin
            starve_cnt <= 4'd0;
        end else if (conflict && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
endmodule

// File: rtl/rv64_mem_arbiter.sv
// Shares one single-port synchronous memory between the fetch and data ports.
// Optional grant/conflict counters are built when RV64_ARB_STATS_EN is defined.
module rv64_mem_arbiter
    import rv64_mem_pkg::*;
#(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req_valid,
    output logic               if_req_ready,
    input  logic [ADDR_W-1:0]  if_req_addr,
    output logic               if_rsp_valid,
    output logic [INSTR_W-1:0] if_rsp_data,
    input  logic               d_req_valid,
    output logic               d_req_ready,
    input  logic               d_req_we,
    input  logic [ADDR_W-1:0]  d_req_addr,
    input  logic [DATA_W-1:0]  d_req_wdata,
    output logic               d_rsp_valid,
    output logic [DATA_W-1:0]  d_rsp_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
`ifdef RV64_ARB_STATS_EN
    ,
    output logic [31:0]        stat_if_grants,
    output logic [31:0]        stat_d_grants,
    output logic [31:0]        stat_conflicts
`endif
);
    localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);

    arb_state_e        state, state_d;
    arb_id_e           grant_id, req_id;
    logic              grant;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic [2:0]        lat_cnt;

    rv64_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (state == IDLE),
        .if_valid (if_req_valid),
        .d_valid  (d_req_valid),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (grant) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (lat_cnt == 3'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request is latched at accept so the requester may change its inputs afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_id    <= ARB_IF;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            lat_cnt   <= 3'd0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    req_id <= grant_id;
                    if (grant_id == ARB_IF) begin
                        req_we    <= 1'b0;
                        req_addr  <= if_req_addr;
                        req_wdata <= '0;
                    end else begin
                        req_we    <= d_req_we;
                        req_addr  <= d_req_addr;
                        req_wdata <= d_req_wdata;
                    end
                end
                ISSUE: lat_cnt <= LAT_LAST;
                WAIT: begin
                    if (lat_cnt == 3'd0) rdata_q <= mem_rdata;
                    else                 lat_cnt <= lat_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if_req_ready = (state == IDLE) && grant && grant_id == ARB_IF;
        d_req_ready  = (state == IDLE) && grant && grant_id == ARB_D;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        d_rsp_valid  = 1'b0;
        d_rsp_rdata  = '0;
        if (state == ISSUE) begin
            mem_en    = 1'b1;
            mem_we    = req_we;
            mem_addr  = req_addr & ~ADDR_W'(7);
            mem_wdata = req_wdata;
        end
        if (state == RESP) begin
            if (req_id == ARB_IF) begin
                if_rsp_valid = 1'b1;
                if_rsp_data  = req_addr[2] ? rdata_q[63:32] : rdata_q[31:0];
            end else begin
                d_rsp_valid = 1'b1;
                d_rsp_rdata = req_we ? '0 : rdata_q;
            end
        end
    end

`ifdef RV64_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_if_grants <= 32'd0;
            stat_d_grants  <= 32'd0;
            stat_conflicts <= 32'd0;
        end else if (state == IDLE) begin
            if (if_req_valid && d_req_valid) stat_conflicts <= stat_conflicts + 32'd1;
            if (grant && grant_id == ARB_IF) stat_if_grants <= stat_if_grants + 32'd1;
            if (grant && grant_id == ARB_D)  stat_d_grants  <= stat_d_grants + 32'd1;
        end
    end
`endif
endmodule
